// File: rtl/parity_pkg.sv
// Shared definitions for the parity frame transmitter and the parity checker.
package parity_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_e;

    localparam int FRAME_BITS = 7;
    localparam int DATA_BITS  = 4;

endpackage

// File: rtl/parity_gen.sv
// Combinational parity of a 4-bit word; odd_i=1 inverts the result for odd parity.
module parity_gen
    import parity_pkg::*;
(
    input  logic [DATA_BITS-1:0] data_i,
    input  logic                 odd_i,
    output logic                 par_o
);

    assign par_o = (^data_i) ^ odd_i;

endmodule

// File: rtl/parity_frame_tx.sv
// Serialises a 4-bit word as start, a..d (MSB first), parity and stop bits,
// each held CLKS_PER_BIT clocks, with a ready/valid handshake on the input side.
module parity_frame_tx
    import parity_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1,
    parameter int ODD_PARITY   = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    input  logic valid,
    output logic ready,
    output logic tx,
    output logic p,
    output logic busy,
    output logic done
);

    localparam int              CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [1:0]             idx_q, idx_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   p_q, p_d;
    logic                   tx_q, tx_d;
    logic                   done_q, done_d;
    logic                   par_w;
    logic                   bit_end;

    parity_gen u_parity_gen (
        .data_i (({a, b, c, d})),
        .odd_i  (1'(ODD_PARITY)),
        .par_o  (par_w)
    );

    assign bit_end = (cnt_q == LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        data_d  = data_q;
        p_d     = p_q;
        case (state_q)
            IDLE: begin
                if (valid) begin
                    state_d = START;
                    cnt_d   = '0;
                    idx_d   = 2'd0;
                    data_d  = {a, b, c, d};
                    p_d     = par_w;
                end
            end
            default: begin
                if (bit_end) begin
                    cnt_d = '0;
                    case (state_q)
                        START:   state_d = DATA;
                        DATA: begin
                            // idx wraps 3->0 on the same boundary that leaves DATA
                            idx_d = idx_q + 2'd1;
                            if (idx_q == 2'd3) state_d = PARITY;
                        end
                        PARITY:  state_d = STOP;
                        default: state_d = IDLE;
                    endcase
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
    end

    // Line and done are derived from the next state so they change with the state register.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = data_d[2'd3 - idx_d];
            PARITY:  tx_d = p_d;
            default: tx_d = 1'b1;
        endcase
        done_d = (state_d == STOP) && (cnt_d == LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= 2'd0;
            data_q  <= '0;
            p_q     <= 1'b0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            p_q     <= p_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    assign ready = (state_q == IDLE);
    assign busy  = (state_q != IDLE);
    assign tx    = tx_q;
    assign p     = p_q;
    assign done  = done_q;

endmodule

// File: doc/parity_frame_tx.md
PARITY_FRAME_TX -- requirements
Module: parity_frame_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 1, meaning clock cycles each serial bit is held (legal range 1..255).
REQ-002 SHALL have parameter ODD_PARITY, default 0, meaning 0 = even parity and 1 = odd parity.
REQ-003 SHALL have port clk, input, 1 bit: single clock, all state on rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port a, input, 1 bit: data bit 3 (MSB, first transmitted).
REQ-006 SHALL have ports b, c, d, input, 1 bit each: data bits 2, 1, 0 (d = LSB).
REQ-007 SHALL have port valid, input, 1 bit: the source offers a, b, c, d.
REQ-008 SHALL have port ready, output, 1 bit: the block accepts a word this cycle.
REQ-009 SHALL have port tx, output, 1 bit: serial frame line, idle high.
REQ-010 SHALL have port p, output, 1 bit: the parity bit computed for the captured word.
REQ-011 SHALL have port busy, output, 1 bit: a frame is in progress.
REQ-012 SHALL have port done, output, 1 bit: one-cycle pulse at the end of the frame.

Function
REQ-013 SHALL accept a word on the rising edge where valid=1 and ready=1, capturing a, b, c, d into an internal register.
REQ-014 SHALL drive ready=1 only in IDLE, combinationally from the state.
REQ-015 SHALL ignore valid while not in IDLE; no queuing.
REQ-016 SHALL compute p = a^b^c^d^ODD_PARITY from the captured word, register it at acceptance, and hold it until the next acceptance.
  - Even mode: a receiver check of data^p yields 0 for an error-free frame.
REQ-017 SHALL use the FSM states IDLE, START, DATA, PARITY, STOP.
REQ-018 SHALL follow these transitions:
  - IDLE->START on acceptance.
  - START->DATA after CLKS_PER_BIT cycles.
  - DATA->PARITY after 4 bits.
  - PARITY->STOP after CLKS_PER_BIT cycles.
  - STOP->IDLE after CLKS_PER_BIT cycles.
REQ-019 SHALL drive tx as follows: IDLE 1; START 0; DATA a, b, c, d in that order; PARITY p; STOP 1; tx SHALL be registered.
REQ-020 SHALL make the start bit visible on tx the first cycle after the acceptance edge (latency 1).
REQ-021 SHALL hold each bit for exactly CLKS_PER_BIT cycles via a bit-period counter that reloads on every bit boundary.
  - Full frame = 7*CLKS_PER_BIT cycles.
REQ-022 SHALL use a 2-bit data index counting 0..3, advancing only at bit boundaries in DATA; wrap from 3 exits to PARITY.
REQ-023 SHALL assert busy in every state except IDLE.
REQ-024 SHALL pulse done for exactly one cycle, coincident with the last cycle of STOP.
REQ-025 SHALL allow back-to-back frames: ready=1 on the cycle after done; a word accepted then starts a frame with no extra idle cycle beyond that one.
REQ-026 SHALL handle CLKS_PER_BIT=1 with no stalls, so each state or bit occupies one cycle.

Reset
REQ-027 SHALL, on rst_n low, immediately force: state IDLE, tx=1, p=0, busy=0, done=0, ready=1 after deassertion, all counters and the data register 0.
REQ-028 SHALL abort any frame in progress when reset asserts mid-frame, with no completion and no done pulse; the line returns high at once.
REQ-029 SHALL accept a word in the first clock edge after rst_n deasserts.

Structure
REQ-030 SHALL place in shared package parity_pkg: the FSM state enum typedef, FRAME_BITS=7, and DATA_BITS=4.
REQ-031 SHALL instantiate one sub-module, parity_gen (combinational XOR of 4 data bits plus mode bit), reusable by the existing checker.
REQ-032 SHALL size the bit-period counter as $clog2(CLKS_PER_BIT+1) bits.

Verification
REQ-033 SHALL cover: CLKS_PER_BIT=1, even, abcd=1011, valid pulse -> tx sequence 0,1,0,1,1,1,1; p=1; done at cycle 7 after acceptance.
REQ-034 SHALL cover: even, abcd=0000 -> tx 0,0,0,0,0,0,1; p=0; ODD_PARITY=1 with the same data -> parity bit 1.
REQ-035 SHALL cover: CLKS_PER_BIT=4, abcd=1100 -> each bit held 4 cycles; frame 28 cycles; busy high 28 cycles; done one cycle.
REQ-036 SHALL cover: valid held high continuously with abcd changing mid-frame -> the second word is taken only on the cycle after done; the first frame is unaffected.
REQ-037 SHALL cover: rst_n driven low during the DATA state -> tx=1 and busy=0 in the same cycle with no clock needed; no done pulse; the next word transmits correctly.
REQ-038 SHALL cover: an exhaustive loop over all 16 words with the existing checker's equation on the received bits -> pec=0 for every frame.
